// File: rtl/qspi_slave_rx.sv
// qspi_slave_rx
//   Receive-only QSPI slave. Oversamples the QSS/QCK/QD pads in the
//   io_mainClk domain, assembles high-then-low nibbles into bytes and
//   queues them, with a first-of-frame tag, in a show-ahead FIFO that
//   drains through a valid/ready stream.
// Ports
//   io_mainClk, reset        : clock, synchronous active-high reset
//   io_qspi_qss/qck/qd_read  : pad inputs (async to io_mainClk)
//   io_qspi_qd_write/_writeEnable : pad drivers, held at 0
//   io_rx_valid/ready/payload/first/occupancy : FIFO output stream
//   io_frameEnd, io_error    : 1-cycle pulses at end of frame / odd nibble
//   io_overflow, io_clearFlags : sticky byte-drop flag and its clear
module qspi_slave_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          io_mainClk,
  input  logic          reset,
  input  logic          io_qspi_qss,
  input  logic          io_qspi_qck,
  input  logic [3:0]    io_qspi_qd_read,
  output logic [3:0]    io_qspi_qd_write,
  output logic [3:0]    io_qspi_qd_writeEnable,
  output logic          io_rx_valid,
  input  logic          io_rx_ready,
  output logic [7:0]    io_rx_payload,
  output logic          io_rx_first,
  output logic [AW:0]   io_rx_occupancy,
  output logic          io_frameEnd,
  output logic          io_error,
  output logic          io_overflow,
  input  logic          io_clearFlags
);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

  // synchronizers: equal depth keeps QD aligned with QCK
  logic [SYNC_STAGES-1:0]      r_qss_sync, r_qck_sync;
  logic [SYNC_STAGES-1:0][3:0] r_qd_sync;
  logic                        r_qss_prev, r_qck_prev;
  // r_settle marks when the sync chain holds real pad values again after
  // reset; r_armed then waits for QSS high so a frame cut by reset is
  // ignored until the next genuine QSS falling edge.
  logic [SYNC_STAGES-1:0]      r_settle;
  logic                        r_armed;

  logic       w_qss_s, w_qck_s;
  logic [3:0] w_qd_s;
  logic       w_rise, w_qss_rise, w_qss_fall;

  assign w_qss_s    = r_qss_sync[SYNC_STAGES-1];
  assign w_qck_s    = r_qck_sync[SYNC_STAGES-1];
  assign w_qd_s     = r_qd_sync[SYNC_STAGES-1];
  assign w_rise     = w_qck_s & ~r_qck_prev;
  assign w_qss_rise = r_armed & w_qss_s & ~r_qss_prev;
  assign w_qss_fall = r_armed & ~w_qss_s & r_qss_prev;

  always_ff @(posedge io_mainClk) begin
    if (reset) begin
      r_qss_sync <= '1;
      r_qck_sync <= '0;
      r_qd_sync  <= '0;
      r_qss_prev <= 1'b1;
      r_qck_prev <= 1'b0;
      r_settle   <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_qss_sync <= {r_qss_sync[SYNC_STAGES-2:0], io_qspi_qss};
      r_qck_sync <= {r_qck_sync[SYNC_STAGES-2:0], io_qspi_qck};
      r_qd_sync  <= {r_qd_sync[SYNC_STAGES-2:0], io_qspi_qd_read};
      r_qss_prev <= w_qss_s;
      r_qck_prev <= w_qck_s;
      r_settle   <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      r_armed    <= r_armed | (r_settle[SYNC_STAGES-1] & w_qss_s);
    end
  end

  // frame FSM
  state_t     r_state, w_state_nxt;
  logic [3:0] r_nib_hi;
  logic       r_first_pending;
  logic       w_push, w_latch_hi, w_end, w_err;

  always_ff @(posedge io_mainClk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // qss_rise takes priority, so a QCK rise in the same cycle is dropped
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_latch_hi  = 1'b0;
    w_end       = 1'b0;
    w_err       = 1'b0;
    if (w_qss_rise) begin
      w_state_nxt = S_IDLE;
      w_end       = 1'b1;
      w_err       = (r_state == S_LO);
    end else begin
      case (r_state)
        S_IDLE: if (w_qss_fall) w_state_nxt = S_HI;
        S_HI: if (w_rise && !w_qss_s) begin
          w_latch_hi  = 1'b1;
          w_state_nxt = S_LO;
        end
        S_LO: if (w_rise && !w_qss_s) begin
          w_push      = 1'b1;
          w_state_nxt = S_HI;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge io_mainClk) begin
    if (reset) begin
      r_nib_hi        <= '0;
      r_first_pending <= 1'b0;
      io_frameEnd     <= 1'b0;
      io_error        <= 1'b0;
    end else begin
      if (w_latch_hi) r_nib_hi <= w_qd_s;
      if (w_qss_fall)  r_first_pending <= 1'b1;
      else if (w_push) r_first_pending <= 1'b0;
      io_frameEnd <= w_end;
      io_error    <= w_err;
    end
  end

  // FIFO: entries are {first, byte}
  logic [8:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_occ;
  logic        w_pop, w_wr;

  assign io_rx_valid = (r_occ != '0);
  assign w_pop       = io_rx_valid & io_rx_ready;
  // a pop in the same cycle frees the slot the push needs
  assign w_wr        = w_push & ((r_occ < (AW+1)'(FIFO_DEPTH)) | w_pop);

  always_ff @(posedge io_mainClk) begin
    if (w_wr) r_mem[r_wptr] <= {r_first_pending, r_nib_hi, w_qd_s};
  end

  always_ff @(posedge io_mainClk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_occ       <= '0;
      io_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
      if (w_push && !w_wr) io_overflow <= 1'b1;
      else if (io_clearFlags) io_overflow <= 1'b0;
    end
  end

  assign io_rx_first     = r_mem[r_rptr][8];
  assign io_rx_payload   = r_mem[r_rptr][7:0];
  assign io_rx_occupancy = r_occ;

  assign io_qspi_qd_write       = 4'h0;
  assign io_qspi_qd_writeEnable = 4'h0;

endmodule

// File: doc/qspi_slave_rx.md
# qspi_slave_rx

Receive-side QSPI slave for the link from the STM32 co-processor into the Murax SoC. It sits directly downstream of the QD/QSS/QCK pads. It oversamples the pad signals in the io_mainClk domain, assembles nibbles into bytes, and buffers them in a small FIFO. The FIFO drains through a valid/ready stream into the SoC's QSPI bus peripheral. The block only receives: it holds the pads as inputs at all times.

## Interface
- FIFO_DEPTH, 16: byte FIFO entries; power of two, ≥2
- SYNC_STAGES, 2: synchronizer flops per pad input; ≥2
- io_mainClk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- io_qspi_qss  input  1  slave select pad, active low
- io_qspi_qck  input  1  QSPI clock pad, mode 0 (sample on rising edge)
- io_qspi_qd_read  input  4  data pad inputs
- io_qspi_qd_write  output  4  pad output data; constant 0
- io_qspi_qd_writeEnable  output  4  pad output enables; constant 0
- io_rx_valid  output  1  FIFO head valid
- io_rx_ready  input  1  consumer accepts head
- io_rx_payload  output  8  head byte
- io_rx_first  output  1  head byte is first byte of its frame
- io_rx_occupancy  output  log2(FIFO_DEPTH)+1  entries stored
- io_frameEnd  output  1  one-cycle pulse when QSS deasserts
- io_error  output  1  one-cycle pulse when a frame ends on an odd nibble
- io_overflow  output  1  sticky: a byte was dropped because the FIFO was full
- io_clearFlags  input  1  clears io_overflow

## Operation
- Synchronizers:
  - QSS, QCK and QD[3:0] each pass through SYNC_STAGES flops. All inputs have equal depth, so data stays aligned with QCK.
  - On reset, the QSS flops load 1 and the QCK/QD flops load 0.
- Edge detect: register qck_prev from the last QCK stage. rise = qck_s & ~qck_prev. Do the same for QSS to get qss_rise and qss_fall.
- Frame state machine:
  - IDLE:
    - qss_fall → HI. Set first_pending=1.
    - rise while in IDLE is ignored.
  - HI: rise and qss_s=0 → latch nib_hi=qd_s, go to LO.
  - LO: rise and qss_s=0 → push {first_pending, nib_hi, qd_s}, clear first_pending, go to HI.
  - Any state with qss_rise:
    - Go to IDLE and pulse io_frameEnd.
    - If the state was LO, also pulse io_error and discard the partial nibble.
  - qss_rise in the same cycle as rise: the rise is ignored.
- Nibble order: high nibble first. The byte is {nib_hi, nib_lo}.
- FIFO (9-bit entries {first, data}):
  - Show-ahead: io_rx_payload and io_rx_first reflect the head whenever io_rx_valid=1. Both are don't-care otherwise.
  - Pop = io_rx_valid & io_rx_ready.
  - A push is accepted if occupancy < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped and io_overflow is set.
  - The state machine advances even when the byte is dropped.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Occupancy = wptr − rptr with one extra bit.
- io_clearFlags:
  - Clears io_overflow.
  - If an overflow occurs in the same cycle, the set wins.
- io_rx_valid = (occupancy != 0).
- io_qspi_qd_write and io_qspi_qd_writeEnable are tied to 0.
- Reset mid-frame:
  - FIFO empties, state goes to IDLE, flags clear.
  - Remaining QCK edges of the current frame are ignored until the next QSS falling edge.

## Timing
- Reset values: io_rx_valid=0, io_rx_occupancy=0, io_frameEnd=0, io_error=0, io_overflow=0, io_qspi_qd_write=0, io_qspi_qd_writeEnable=0.
- Pad to detect: a pin transition is detected SYNC_STAGES+1 cycles after it is first sampled.
- The FIFO write happens on the cycle in which the low-nibble rise is detected. io_rx_valid goes high one cycle later.
- Pop-to-update: occupancy and the head update on the cycle after a pop.
- Back-to-back pops are supported, one byte per cycle.
- io_frameEnd and io_error are asserted for exactly 1 cycle, in the cycle after qss_rise is detected.
- Legal QCK rate: QCK high and QCK low must each last ≥ SYNC_STAGES+1 io_mainClk periods.
- QD and QSS must be stable one QCK half-period around the QCK rising edge.

## Test plan
- Single frame:
  - Stimulus: QSS low, nibbles 0xA,0x5,0x3,0xC, QSS high; io_rx_ready=1.
  - Required: stream 0xA5 (first=1), then 0x3C (first=0); one io_frameEnd pulse; io_error=0.
- Odd nibble count:
  - Stimulus: nibbles 0x1,0x2,0x3, then QSS high.
  - Required: FIFO holds only 0x12; io_error pulses once, in the same cycle as io_frameEnd.
- Overflow:
  - Stimulus: io_rx_ready=0, send 17 bytes 0x00..0x10 with FIFO_DEPTH=16.
  - Required: occupancy=16; io_overflow=1; drained bytes are 0x00..0x0F.
  - Then pulse io_clearFlags → io_overflow=0.
- Full with simultaneous pop:
  - Stimulus: FIFO full; pulse io_rx_ready exactly on the write cycle of byte 0x77.
  - Required: 0x77 is accepted; occupancy stays 16; io_overflow stays 0.
- Reset mid-frame:
  - Stimulus: after the high nibble 0xF, assert reset for 1 cycle; continue with nibble 0x0, then a new frame 0x4,0x2.
  - Required: only 0x42 is received, with first=1.
- Pointer wrap:
  - Stimulus: 40 consecutive bytes 0x00..0x27 with io_rx_ready toggling every cycle.
  - Required: all 40 bytes delivered in order; io_overflow=0.
